mem_sys: RTL and testbench
==========================

MEM_SYS -- requirements
Module: mem_sys

Interface
REQ-001 Parameter depth_words, default 1024, memory size in 32-bit words (power of two, 16..65536).
REQ-002 Parameter base_addr [31:0], default 0, byte address of word 0.
REQ-003 Parameter wait_states, default 2, idle cycles inserted per access (0..15).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 instr_req  input  1  instruction fetch request, sampled in IDLE.
REQ-007 instr_addr  input  32  fetch byte address.
REQ-008 instr_out  output  32  fetched word.
REQ-009 instr_valid  output  1  one-cycle pulse, instr_out/instr_err valid.
REQ-010 instr_err  output  1  fetch address error, qualified by instr_valid.
REQ-011 data_req  input  1  data access request, sampled in IDLE.
REQ-012 data_rd_wr  input  1  1 = read, 0 = write.
REQ-013 data_addr  input  32  data byte address.
REQ-014 data_in  input  32  write data from core.
REQ-015 data_out  output  32  read data to core.
REQ-016 data_valid  output  1  one-cycle pulse, access complete.
REQ-017 data_err  output  1  data address error, qualified by data_valid.

Function
REQ-018 Instruction and data ports SHALL each run an independent FSM: IDLE, WAIT, RESP.
REQ-019 IDLE with req=1: capture addr, rd_wr, write data; load counter with wait_states; go to WAIT, or directly to RESP if wait_states=0.
REQ-020 WAIT: counter decrements each cycle; at counter=1, go to RESP.
REQ-021 RESP: perform access, assert valid for exactly one cycle, return to IDLE; a req is accepted again only in the following IDLE cycle.
REQ-022 Latency SHALL be wait_states+1 cycles from the sampling edge to valid high.
REQ-023 req while in WAIT or RESP SHALL be ignored (no queueing).
REQ-024 Word index = (addr - base_addr) >> 2, unsigned 32-bit subtraction wrapping modulo 2^32.
REQ-025 Error if addr[1:0] != 0 or index >= depth_words: err=1 with valid; read data=0; no write.
REQ-026 Reads SHALL return the full 32-bit word; writes SHALL update the full word; no byte enables.
REQ-027 Both ports SHALL access one shared word array; the instruction port is read-only.
REQ-028 Data write and instruction read of the same word in the same RESP cycle: the instruction read SHALL return the old value.
REQ-029 Outside RESP, instr_out and data_out SHALL hold their last value; err SHALL be 0.
REQ-030 A data write SHALL set data_out to 0.

Reset
REQ-031 reset=0 SHALL immediately force both FSMs to IDLE, counters to 0, and all outputs to 0.
REQ-032 An access in flight when reset asserts SHALL be aborted, with no write and no valid pulse.
REQ-033 Memory array contents SHALL NOT be affected by reset.
REQ-034 First request accepted on the first rising edge with reset=1.

Structure
REQ-035 Shared package mem_pkg SHALL hold the enum MEM_PORT_STATE {IDLE, WAIT, RESP} and the constants MEM_READ=1 and MEM_WRITE=0.
REQ-036 Sub-module mem_port_ctrl SHALL implement one port FSM, counter and error check, instantiated twice; the array lives in mem_sys.

Verification
REQ-037 wait_states=2, write 0xDEADBEEF to 0x10, then read 0x10: data_valid 3 cycles after each request; read returns 0xDEADBEEF; data_err=0.
REQ-038 Read 0x12 (misaligned) and 0x1000 (depth 1024): data_valid with data_err=1, data_out=0; a later read of 0x0 returns the unchanged contents.
REQ-039 Instruction read and data write of 0x20 (old value 0x11111111, new 0x22222222) in the same cycle: instr_out=0x11111111; a next fetch returns 0x22222222.
REQ-040 Assert reset at the WAIT cycle of a write of 0x55 to 0x8: no data_valid pulse; a later read of 0x8 returns the prior value.
REQ-041 wait_states=0, back-to-back data_req held high: valid every 2nd cycle; requests presented during RESP are ignored.
REQ-042 base_addr=0x400, fetch 0x3FC: instr_err=1 (wrapped index out of range); fetch 0x400 returns word 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the dual-port memory subsystem: port FSM states, access direction
// and the per-port access request presented to the shared word array.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } MEM_PORT_STATE;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;
    localparam int   WIDX_W    = 30;

    typedef struct packed {
        logic              vld;
        logic              rd_wr;
        logic              err;
        logic [WIDX_W-1:0] idx;
        logic [31:0]       wdata;
    } mem_acc_t;

    // Word index relative to the window base; the subtraction wraps, so addresses below
    // the base land far out of range instead of aliasing onto low words.
    function automatic logic [WIDX_W-1:0] word_index(input logic [31:0] addr,
                                                     input logic [31:0] base);
        return WIDX_W'((addr - base) >> 2);
    endfunction

    function automatic logic addr_error(input logic [31:0] addr, input logic [31:0] base,
                                        input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, word_index(addr, base)} >= depth);
    endfunction

endpackage

// File: rtl/mem_port_ctrl.sv
// One memory port: IDLE/WAIT/RESP sequencer with a wait-state counter, address check and
// registered response outputs. The array itself lives in the parent.
module mem_port_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned depth_words = 1024,
    parameter logic [31:0] base_addr   = 32'h0,
    parameter int unsigned wait_states = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        rd_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output mem_acc_t    acc,
    input  logic [31:0] rdata,
    output logic [31:0] out,
    output logic        valid,
    output logic        err
);

    localparam logic [3:0] WS = 4'(wait_states);

    MEM_PORT_STATE state;
    logic [3:0]    cnt;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          rd_wr_q;
    logic          acc_err;

    assign acc_err = addr_error(addr_q, base_addr, depth_words);

    // The array acts on this only while in RESP; the parent gates writes with vld.
    always_comb begin
        acc       = '0;
        acc.vld   = (state == RESP);
        acc.rd_wr = rd_wr_q;
        acc.err   = acc_err;
        acc.idx   = word_index(addr_q, base_addr);
        acc.wdata = wdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rd_wr_q <= MEM_READ;
            out     <= 32'h0;
            valid   <= 1'b0;
            err     <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        rd_wr_q <= rd_wr;
                        cnt     <= WS;
                        state   <= (WS == 4'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP: begin
                    // Writes and faulting accesses report zero data.
                    valid <= 1'b1;
                    err   <= acc_err;
                    out   <= (acc_err || rd_wr_q == MEM_WRITE) ? 32'h0 : rdata;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_sys.sv
// Shared word memory with a read-only instruction port and a read/write data port,
// each sequenced by its own mem_port_ctrl.
module mem_sys
    import mem_pkg::*;
#(
    parameter int unsigned depth_words = 1024,
    parameter logic [31:0] base_addr   = 32'h0,
    parameter int unsigned wait_states = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic        instr_err,
    input  logic        data_req,
    input  logic        data_rd_wr,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        data_err
);

    localparam int AW = $clog2(depth_words);

    logic [31:0] mem [depth_words];
    mem_acc_t    i_acc;
    mem_acc_t    d_acc;
    logic [31:0] i_rdata;
    logic [31:0] d_rdata;
    logic        unused_acc;

    mem_port_ctrl #(
        .depth_words (depth_words),
        .base_addr   (base_addr),
        .wait_states (wait_states)
    ) u_iport (
        .clk   (clk),
        .reset (reset),
        .req   (instr_req),
        .rd_wr (MEM_READ),
        .addr  (instr_addr),
        .wdata (32'h0),
        .acc   (i_acc),
        .rdata (i_rdata),
        .out   (instr_out),
        .valid (instr_valid),
        .err   (instr_err)
    );

    mem_port_ctrl #(
        .depth_words (depth_words),
        .base_addr   (base_addr),
        .wait_states (wait_states)
    ) u_dport (
        .clk   (clk),
        .reset (reset),
        .req   (data_req),
        .rd_wr (data_rd_wr),
        .addr  (data_addr),
        .wdata (data_in),
        .acc   (d_acc),
        .rdata (d_rdata),
        .out   (data_out),
        .valid (data_valid),
        .err   (data_err)
    );

    // Reads are combinational off the array; a same-edge data write is non-blocking, so a
    // colliding instruction fetch captures the pre-write word.
    assign i_rdata = mem[i_acc.idx[AW-1:0]];
    assign d_rdata = mem[d_acc.idx[AW-1:0]];

    // No reset: contents survive reset by design.
    always_ff @(posedge clk) begin
        if (d_acc.vld && d_acc.rd_wr == MEM_WRITE && !d_acc.err)
            mem[d_acc.idx[AW-1:0]] <= d_acc.wdata;
    end

    assign unused_acc = ^{i_acc.vld, i_acc.rd_wr, i_acc.err, i_acc.wdata,
                          i_acc.idx[WIDX_W-1:AW], d_acc.idx[WIDX_W-1:AW]};

endmodule

// File: tb/tb_mem_sys.sv
// Randomized scoreboard bench for mem_sys: one instance with two wait states at base 0,
// one with zero wait states at base 0x400.
module tb_mem_sys;

    localparam int DEPTH = 1024;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic [1:0]  rst;
    logic [1:0]  ireq, dreq, drw;
    logic [31:0] iaddr [2];
    logic [31:0] daddr [2];
    logic [31:0] din   [2];
    wire  [31:0] iout  [2];
    wire  [31:0] dout  [2];
    wire  [1:0]  ivld, ierr, dvld, derr;

    exp_t        q0i[$], q0d[$], q1i[$], q1d[$];
    logic [31:0] mm [longint];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_sys #(.depth_words(DEPTH), .base_addr(32'h0), .wait_states(2)) u_dut_a (
        .clk(clk), .reset(rst[0]),
        .instr_req(ireq[0]), .instr_addr(iaddr[0]), .instr_out(iout[0]),
        .instr_valid(ivld[0]), .instr_err(ierr[0]),
        .data_req(dreq[0]), .data_rd_wr(drw[0]), .data_addr(daddr[0]), .data_in(din[0]),
        .data_out(dout[0]), .data_valid(dvld[0]), .data_err(derr[0])
    );

    mem_sys #(.depth_words(DEPTH), .base_addr(32'h400), .wait_states(0)) u_dut_b (
        .clk(clk), .reset(rst[1]),
        .instr_req(ireq[1]), .instr_addr(iaddr[1]), .instr_out(iout[1]),
        .instr_valid(ivld[1]), .instr_err(ierr[1]),
        .data_req(dreq[1]), .data_rd_wr(drw[1]), .data_addr(daddr[1]), .data_in(din[1]),
        .data_out(dout[1]), .data_valid(dvld[1]), .data_err(derr[1])
    );

    function automatic int ws(int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic logic [31:0] base(int d);
        return (d == 0) ? 32'h0 : 32'h400;
    endfunction

    // Reference model: the memory is a sparse map from (instance, word) to value.
    function automatic logic m_err(int d, logic [31:0] a);
        logic [31:0] w;
        w = (a - base(d)) >> 2;
        return (a[1:0] != 2'b00) || (w >= 32'(DEPTH));
    endfunction

    function automatic longint key(int d, logic [31:0] a);
        logic [31:0] w;
        w = (a - base(d)) >> 2;
        return {32'(d), w};
    endfunction

    function automatic logic [31:0] m_rd(int d, logic [31:0] a);
        longint k;
        k = key(d, a);
        return mm.exists(k) ? mm[k] : 32'h0;
    endfunction

    task automatic push(int d, int p, logic [31:0] v, logic e, int c);
        exp_t x;
        x.data = v; x.err = e; x.cyc = c;
        case ({d[0], p[0]})
            2'b00:   q0i.push_back(x);
            2'b01:   q0d.push_back(x);
            2'b10:   q1i.push_back(x);
            default: q1d.push_back(x);
        endcase
    endtask

    function automatic int qsz(int d, int p);
        case ({d[0], p[0]})
            2'b00:   return q0i.size();
            2'b01:   return q0d.size();
            2'b10:   return q1i.size();
            default: return q1d.size();
        endcase
    endfunction

    task automatic qpop(int d, int p, output exp_t x);
        case ({d[0], p[0]})
            2'b00:   x = q0i.pop_front();
            2'b01:   x = q0d.pop_front();
            2'b10:   x = q1i.pop_front();
            default: x = q1d.pop_front();
        endcase
    endtask

    task automatic ceq(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Called at a falling edge with the port idle; returns at the falling edge before the
    // first rising edge on which the port can accept again.
    task automatic issue(int d, bit fi, logic [31:0] ia, bit fd, bit rd,
                         logic [31:0] da, logic [31:0] wd);
        logic e;
        ireq[d] = fi; iaddr[d] = ia;
        dreq[d] = fd; drw[d] = rd; daddr[d] = da; din[d] = wd;
        if (fi) begin
            e = m_err(d, ia);
            push(d, 0, e ? 32'h0 : m_rd(d, ia), e, cyc + ws(d) + 2);
        end
        if (fd) begin
            e = m_err(d, da);
            push(d, 1, (e || !rd) ? 32'h0 : m_rd(d, da), e, cyc + ws(d) + 2);
            if (!e && !rd) mm[key(d, da)] = wd;
        end
        @(posedge clk);
        @(negedge clk);
        ireq[d] = 1'b0;
        dreq[d] = 1'b0;
        repeat (ws(d) + 1) @(negedge clk);
    endtask

    function automatic logic [31:0] pick(int d);
        int r = $urandom_range(0, 15);
        int nlo = (d == 0) ? 32 : 16;
        case (r)
            11:      return base(d) + 32'd4092;
            12:      return base(d) + 32'($urandom_range(0, nlo - 1)) * 32'd4 + 32'($urandom_range(1, 3));
            13:      return base(d) + 32'd4096;
            14:      return base(d) - 32'd4;
            15:      return 32'($urandom) | 32'h1;
            default: return base(d) + 32'($urandom_range(0, nlo - 1)) * 32'd4;
        endcase
    endfunction

    task automatic rand_slot(int d);
        bit fi = ($urandom_range(0, 3) != 0);
        bit fd = ($urandom_range(0, 3) != 0);
        bit rd = ($urandom_range(0, 1) != 0);
        logic [31:0] ia = pick(d);
        logic [31:0] da = ($urandom_range(0, 3) == 0) ? ia : pick(d);
        issue(d, fi, ia, fd, rd, da, 32'($urandom));
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic chk(int d, int p, logic v, logic [31:0] o, logic e);
        exp_t x;
        checks++;
        if (!v) begin
            if (e) begin
                errors++;
                $display("FAIL dut%0d port%0d err_without_valid got err=1 want err=0", d, p);
            end
        end else if (qsz(d, p) == 0) begin
            errors++;
            $display("FAIL dut%0d port%0d unexpected_valid got data=%h err=%b want no pulse",
                     d, p, o, e);
        end else begin
            qpop(d, p, x);
            if (o !== x.data || e !== x.err || cyc != x.cyc) begin
                errors++;
                $display("FAIL dut%0d port%0d response got data=%h err=%b cyc=%0d want data=%h err=%b cyc=%0d",
                         d, p, o, e, cyc, x.data, x.err, x.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk(d, 0, ivld[d], iout[d], ierr[d]);
            chk(d, 1, dvld[d], dout[d], derr[d]);
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog got no finish want finish before time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 2'b00; ireq = '0; dreq = '0; drw = '0;
        for (int d = 0; d < 2; d++) begin
            iaddr[d] = '0; daddr[d] = '0; din[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            ceq("reset_instr_out", iout[d], 32'h0);
            ceq("reset_data_out", dout[d], 32'h0);
            ceq("reset_flags", 32'({ivld[d], ierr[d], dvld[d], derr[d]}), 32'h0);
        end

        // Instance A: the first request goes in on the edge right after reset release.
        rst = 2'b11;
        issue(0, 0, 0, 1, 0, 32'h10, 32'hDEADBEEF);
        issue(0, 0, 0, 1, 1, 32'h10, 0);
        for (int i = 0; i < 32; i++) issue(0, 0, 0, 1, 0, 32'(i * 4), 32'($urandom));
        issue(0, 0, 0, 1, 0, 32'd4092, 32'($urandom));
        issue(0, 0, 0, 1, 1, 32'h12, 0);
        issue(0, 0, 0, 1, 1, 32'h1000, 0);
        issue(0, 0, 0, 1, 1, 32'h0, 0);
        issue(0, 0, 0, 1, 0, 32'h20, 32'h11111111);
        issue(0, 1, 32'h20, 1, 0, 32'h20, 32'h22222222);
        issue(0, 1, 32'h20, 0, 0, 0, 0);

        // Reset lands while a write to 0x8 is waiting: no pulse, no write.
        dreq[0] = 1'b1; drw[0] = 1'b0; daddr[0] = 32'h8; din[0] = 32'h55;
        @(posedge clk);
        @(negedge clk);
        dreq[0] = 1'b0;
        rst[0] = 1'b0;
        #1;
        ceq("abort_instr_out", iout[0], 32'h0);
        ceq("abort_data_out", dout[0], 32'h0);
        ceq("abort_flags", 32'({ivld[0], ierr[0], dvld[0], derr[0]}), 32'h0);
        repeat (3) @(negedge clk);
        rst[0] = 1'b1;
        issue(0, 0, 0, 1, 1, 32'h8, 0);
        for (int n = 0; n < 200; n++) rand_slot(0);

        // Instance B: base 0x400, zero wait states.
        for (int i = 0; i < 16; i++) issue(1, 0, 0, 1, 0, 32'h400 + 32'(i * 4), 32'($urandom));
        issue(1, 0, 0, 1, 0, 32'h400 + 32'd4092, 32'($urandom));
        issue(1, 1, 32'h3FC, 0, 0, 0, 0);
        issue(1, 1, 32'h400, 0, 0, 0, 0);
        begin
            // Request held high for 7 edges: accepted on every other edge only.
            int n0;
            n0 = cyc;
            dreq[1] = 1'b1; drw[1] = 1'b1; daddr[1] = 32'h400;
            for (int k = 0; k < 4; k++) push(1, 1, m_rd(1, 32'h400), 1'b0, n0 + 2 + 2 * k);
            repeat (7) @(negedge clk);
            dreq[1] = 1'b0;
            repeat (2) @(negedge clk);
        end
        for (int n = 0; n < 100; n++) rand_slot(1);

        repeat (8) @(negedge clk);
        ceq("drain_a_instr", 32'(q0i.size()), 32'h0);
        ceq("drain_a_data", 32'(q0d.size()), 32'h0);
        ceq("drain_b_instr", 32'(q1i.size()), 32'h0);
        ceq("drain_b_data", 32'(q1d.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
